z80_ld_ind_seq: RTL and testbench
=================================

# z80_ld_ind_seq

Multi-cycle execution sequencer for the Z80 "load register from memory" family: LD r,(HL), LD A,(BC), LD A,(DE), LD r,(IX+d) and LD r,(IY+d). It sits behind the core's opcode decoder: it takes over after the M1 fetch, runs the displacement, internal and memory-read M-cycles T-state by T-state with WAIT handling, and writes the result through the core's register-file write port. It generalises the single fixed-mode 4T+3T load with a selectable address source, an indexed mode, wait states and per-M-cycle T-state reporting for the z80fi checkers.

## Interface
Parameters:
- INDEXED, 1: when 1, the IX+d and IY+d modes are supported; when 0, modes 3 and 4 raise err.
- TCYC_W, 4: width of the T-state counters; counters saturate at 2^TCYC_W-1.

Ports:
- clk  in  1  Single clock; one T-state per clk.
- reset  in  1  Synchronous, active-high.
- start  in  1  Begin an instruction; sampled only in IDLE.
- mode  in  3  Address source: 0 HL, 1 BC, 2 DE, 3 IX+d, 4 IY+d; 5-7 illegal.
- r  in  3  Destination register (B,C,D,E,H,L,-,A encoding).
- hl, bc, de, ix, iy  in  16 each  Register values, captured at start.
- ip_in  in  16  Address of the byte following the opcode.
- bus_rdata  in  8  Memory read data.
- bus_wait  in  1  WAIT request, sampled in T2 of each read.
- busy  out  1  High from the cycle after start is accepted until done.
- bus_addr  out  16  Memory address.
- bus_mreq, bus_rd  out  1 each  Asserted in T1 through T3 of each memory read.
- reg_we  out  1  One-cycle register-write strobe.
- reg_sel  out  3  Register to write (equals r).
- reg_wdata  out  8  Byte to write.
- ip_out  out  16  Updated instruction pointer, valid with done.
- done  out  1  One-cycle completion pulse.
- err  out  1  One-cycle illegal-request pulse; no bus activity and no write.
- tcyc_m2, tcyc_m3, tcyc_m4  out  TCYC_W each  T-states spent in M2, M3 and M4; valid with done.

## Operation
- **States:** IDLE, D_T1, D_T2, D_T3, INT, R_T1, R_T2, R_T3, FIN.
- **Illegal requests:** on start, the request is illegal if r==6, or mode is 5-7, or mode is 1 or 2 with r!=7, or mode is 3 or 4 with INDEXED=0. For an illegal request:
  - err pulses in the next cycle.
  - The block stays in IDLE.
- **Legal, non-indexed (modes 0-2):** IDLE→R_T1. Address = captured HL, BC or DE.
- **Legal, indexed (modes 3-4):**
  - Path: IDLE→D_T1→D_T2→D_T3→INT, hold INT for 5 cycles, then →R_T1.
  - The displacement is read at ip_in.
  - Read address = IX/IY + sign-extended d, modulo 2^16.
- **Wait states:** in D_T2 and R_T2, if bus_wait is high the state repeats. The exit goes to T3 on the first cycle with bus_wait low.
- **Data capture:** bus_rdata is captured at the end of R_T3 (and at the end of D_T3 for d).
- **FIN state (one cycle):**
  - reg_we=1, reg_sel=r, reg_wdata=captured byte, done=1.
  - ip_out = ip_in (non-indexed) or ip_in+1 mod 2^16 (indexed).
  - Next state IDLE.
- **T-state counts:**
  - Non-indexed: tcyc_m2 = read T-states; tcyc_m3 and tcyc_m4 = 0.
  - Indexed: tcyc_m2 = displacement read, tcyc_m3 = 5, tcyc_m4 = data read.
  - Counters saturate and do not wrap.
- **start while busy:** ignored.
- **Inputs after capture:** register inputs are not re-sampled after capture, so changes during execution have no effect.

## Timing
- **Reset:** all outputs 0 (bus_addr=0, ip_out=0, tcyc_*=0, busy=0), state IDLE.
- **Reset mid-operation:** the next cycle is IDLE with all outputs 0. No reg_we and no done are produced for the aborted instruction.
- **Latency with no waits (start accepted at cycle 0):**
  - Non-indexed: done at cycle 4.
  - Indexed: done at cycle 12.
  - Each wait cycle adds 1.
- **Registered outputs:** all outputs are registered. bus_mreq and bus_rd are high exactly in T1, T2 (including repeats) and T3. bus_addr is stable over that window.
- **Back-to-back:** start may be accepted in the IDLE cycle right after FIN.
- **busy:** high from cycle 1 through the FIN cycle inclusive.

## Test plan
- **Non-indexed, HL:** mode 0, r=0 (B), HL=0x1234, memory[0x1234]=0x5A, ip_in=0x0101, no wait → bus_addr=0x1234 in cycles 1-3; at cycle 4 reg_we=1, reg_sel=0, reg_wdata=0x5A, ip_out=0x0101, tcyc_m2=3, done=1.
- **Indexed, negative displacement and wrap:** mode 3, r=7, IX=0x0002, d=0xFD (-3), ip_in=0xFFFF → displacement read at 0xFFFF, data read at 0xFFFF; done at cycle 12; ip_out=0x0000; tcyc_m2=3, tcyc_m3=5, tcyc_m4=3.
- **Wait states:** mode 2, r=7, bus_wait high for 2 cycles in R_T2 → done at cycle 6, tcyc_m2=5. With TCYC_W=2 and 5 waits → tcyc_m2=3 (saturated).
- **Illegal requests:** r=6 with mode 0; mode 1 with r=3; mode 6; mode 4 with INDEXED=0 → err pulse at cycle 1, busy stays 0, no bus_mreq, no reg_we.
- **Reset mid-operation:** indexed start, reset asserted in INT → next cycle all outputs 0, no done. A subsequent HL load completes normally.
- **start while busy:** start re-asserted during R_T2 with different r → ignored; only the original r is written. A start in the cycle after FIN is accepted.

Source files
------------

// File: rtl/z80_ld_ind_seq.sv
// z80_ld_ind_seq: T-state sequencer for LD r,(HL/BC/DE) and LD r,(IX+d/IY+d) with WAIT handling
module z80_ld_ind_seq #(
  parameter bit INDEXED = 1'b1,
  parameter int TCYC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic [2:0]        r,
  input  logic [15:0]       hl,
  input  logic [15:0]       bc,
  input  logic [15:0]       de,
  input  logic [15:0]       ix,
  input  logic [15:0]       iy,
  input  logic [15:0]       ip_in,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_wait,
  output logic              busy,
  output logic [15:0]       bus_addr,
  output logic              bus_mreq,
  output logic              bus_rd,
  output logic              reg_we,
  output logic [2:0]        reg_sel,
  output logic [7:0]        reg_wdata,
  output logic [15:0]       ip_out,
  output logic              done,
  output logic              err,
  output logic [TCYC_W-1:0] tcyc_m2,
  output logic [TCYC_W-1:0] tcyc_m3,
  output logic [TCYC_W-1:0] tcyc_m4
);
  typedef enum logic [3:0] {IDLE, D_T1, D_T2, D_T3, INT, R_T1, R_T2, R_T3, FIN} state_t;
  localparam int M3 = ((1 << TCYC_W) - 1 < 5) ? (1 << TCYC_W) - 1 : 5;
  state_t st;
  logic [15:0] base, ip;
  logic idx;
  logic [2:0] ic;
  logic [TCYC_W-1:0] tc, tc_inc;
  logic illegal, idx_req;
  logic [15:0] sel;
  assign idx_req = mode == 3'd3 || mode == 3'd4;
  assign illegal = (r == 3'd6) || (mode > 3'd4) ||
                   ((mode == 3'd1 || mode == 3'd2) && r != 3'd7) || (idx_req && !INDEXED);
  assign sel = mode == 3'd0 ? hl : mode == 3'd1 ? bc : mode == 3'd2 ? de : mode == 3'd3 ? ix : iy;
  assign tc_inc = (&tc) ? tc : tc + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      busy <= 1'b0;
      bus_addr <= '0;
      bus_mreq <= 1'b0;
      bus_rd <= 1'b0;
      reg_we <= 1'b0;
      reg_sel <= '0;
      reg_wdata <= '0;
      ip_out <= '0;
      done <= 1'b0;
      err <= 1'b0;
      tcyc_m2 <= '0;
      tcyc_m3 <= '0;
      tcyc_m4 <= '0;
      base <= '0;
      ip <= '0;
      idx <= 1'b0;
      ic <= '0;
      tc <= '0;
    end else begin
      err <= 1'b0;
      done <= 1'b0;
      reg_we <= 1'b0;
      case (st)
        IDLE: if (start) begin
          if (illegal) err <= 1'b1;
          else begin
            busy <= 1'b1;
            bus_mreq <= 1'b1;
            bus_rd <= 1'b1;
            tc <= TCYC_W'(1);
            idx <= idx_req;
            reg_sel <= r;
            ip <= ip_in;
            base <= sel;
            tcyc_m2 <= '0;
            tcyc_m3 <= '0;
            tcyc_m4 <= '0;
            bus_addr <= idx_req ? ip_in : sel;
            st <= idx_req ? D_T1 : R_T1;
          end
        end
        D_T1, R_T1: begin
          tc <= tc_inc;
          st <= (st == D_T1) ? D_T2 : R_T2;
        end
        D_T2, R_T2: begin
          tc <= tc_inc;
          if (!bus_wait) st <= (st == D_T2) ? D_T3 : R_T3;
        end
        D_T3: begin
          base <= base + {{8{bus_rdata[7]}}, bus_rdata};
          tcyc_m2 <= tc;
          bus_mreq <= 1'b0;
          bus_rd <= 1'b0;
          ic <= 3'd1;
          st <= INT;
        end
        INT: if (ic == 3'd5) begin
          bus_mreq <= 1'b1;
          bus_rd <= 1'b1;
          bus_addr <= base;
          tc <= TCYC_W'(1);
          st <= R_T1;
        end else ic <= ic + 3'd1;
        R_T3: begin
          reg_wdata <= bus_rdata;
          bus_mreq <= 1'b0;
          bus_rd <= 1'b0;
          reg_we <= 1'b1;
          done <= 1'b1;
          ip_out <= idx ? ip + 16'd1 : ip;
          if (idx) begin
            tcyc_m3 <= TCYC_W'(M3);
            tcyc_m4 <= tc;
          end else tcyc_m2 <= tc;
          st <= FIN;
        end
        FIN: begin
          busy <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z80_ld_ind_seq.sv
// tb_z80_ld_ind_seq: randomized self-checking bench with a cycle-level reference model
module tb_z80_ld_ind_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, bus_wait = 1'b0;
  logic [2:0] mode = '0, r = '0;
  logic [15:0] hl = '0, bc = '0, de = '0, ix = '0, iy = '0, ip_in = '0;
  logic [7:0] mem [65536];
  logic [7:0] bus_rdata, bus_rdata2;
  logic busy, bus_mreq, bus_rd, reg_we, done, err;
  logic [15:0] bus_addr, ip_out;
  logic [2:0] reg_sel;
  logic [7:0] reg_wdata;
  logic [3:0] tcyc_m2, tcyc_m3, tcyc_m4;
  logic busy2, bus_mreq2, bus_rd2, reg_we2, done2, err2;
  logic [15:0] bus_addr2, ip_out2;
  logic [2:0] reg_sel2;
  logic [7:0] reg_wdata2;
  logic [1:0] tcyc2_m2, tcyc2_m3, tcyc2_m4;
  int total = 0, passed = 0;

  always #5 clk = ~clk;
  assign bus_rdata = mem[bus_addr];
  assign bus_rdata2 = mem[bus_addr2];

  z80_ld_ind_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .r(r),
    .hl(hl), .bc(bc), .de(de), .ix(ix), .iy(iy), .ip_in(ip_in),
    .bus_rdata(bus_rdata), .bus_wait(bus_wait), .busy(busy), .bus_addr(bus_addr),
    .bus_mreq(bus_mreq), .bus_rd(bus_rd), .reg_we(reg_we), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .ip_out(ip_out), .done(done), .err(err),
    .tcyc_m2(tcyc_m2), .tcyc_m3(tcyc_m3), .tcyc_m4(tcyc_m4)
  );

  z80_ld_ind_seq #(.INDEXED(1'b0), .TCYC_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .r(r),
    .hl(hl), .bc(bc), .de(de), .ix(ix), .iy(iy), .ip_in(ip_in),
    .bus_rdata(bus_rdata2), .bus_wait(bus_wait), .busy(busy2), .bus_addr(bus_addr2),
    .bus_mreq(bus_mreq2), .bus_rd(bus_rd2), .reg_we(reg_we2), .reg_sel(reg_sel2),
    .reg_wdata(reg_wdata2), .ip_out(ip_out2), .done(done2), .err(err2),
    .tcyc_m2(tcyc2_m2), .tcyc_m3(tcyc2_m3), .tcyc_m4(tcyc2_m4)
  );

  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction

  // One instruction from start to the first IDLE cycle after FIN; expectations come from
  // the instruction's documented cycle budget, not from any internal state.
  task automatic do_load(input int m, input int rr, input int wd, input int wr, input bit poke, input string nm);
    logic [15:0] base, addr, ip0, ipx;
    logic [7:0] data;
    logic [5:0] ectl, octl;
    logic [3:0] ectl2, octl2;
    logic [46:0] eres, ores;
    int d, lat;
    bit idx, inr, inw, t2x;
    idx = m >= 3;
    base = m == 0 ? hl : m == 1 ? bc : m == 2 ? de : m == 3 ? ix : iy;
    ip0 = ip_in;
    d = int'(mem[ip0]);
    if (d > 127) d -= 256;
    addr = idx ? 16'((int'(base) + d) & 16'hFFFF) : base;
    data = mem[addr];
    ipx = idx ? 16'((int'(ip0) + 1) & 16'hFFFF) : ip0;
    lat = idx ? 12 + wd + wr : 4 + wr;
    eres = {3'(rr), data, ipx, 4'(sat(3 + (idx ? wd : wr), 4)), 4'(idx ? 5 : 0), 4'(idx ? sat(3 + wr, 4) : 0)};
    mode = 3'(m);
    r = 3'(rr);
    start = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      start = poke && c == 2;
      if (c == 1) begin
        hl = 16'($urandom); bc = 16'($urandom); de = 16'($urandom);
        ix = 16'($urandom); iy = 16'($urandom); ip_in = 16'($urandom);
      end
      if (c == 2) r = 3'(rr ^ 1);
      inw = idx ? ((c >= 2 && c < 2 + wd) || (c >= 10 + wd && c < 10 + wd + wr)) : (c >= 2 && c < 2 + wr);
      t2x = idx ? (c == 2 + wd || c == 10 + wd + wr) : (c == 2 + wr);
      bus_wait = inw || (!t2x && $urandom_range(0, 1) == 1);
      @(negedge clk);
      inr = idx ? (c <= 3 + wd || (c >= 9 + wd && c <= 11 + wd + wr)) : (c <= 3 + wr);
      ectl = {c <= lat, inr, inr, c == lat, c == lat, 1'b0};
      octl = {busy, bus_mreq, bus_rd, done, reg_we, err};
      total++;
      if (octl !== ectl) $display("FAIL %s ctl c=%0d got %b exp %b", nm, c, octl, ectl);
      else passed++;
      if (inr) begin
        total++;
        if (bus_addr !== ((idx && c <= 3 + wd) ? ip0 : addr))
          $display("FAIL %s addr c=%0d got %h exp %h", nm, c, bus_addr, (idx && c <= 3 + wd) ? ip0 : addr);
        else passed++;
      end
      if (c == lat) begin
        ores = {reg_sel, reg_wdata, ip_out, tcyc_m2, tcyc_m3, tcyc_m4};
        total++;
        if (ores !== eres) $display("FAIL %s result got %h exp %h", nm, ores, eres);
        else passed++;
      end
      if (!idx) begin
        ectl2 = {c <= lat, c == lat, c == lat, 1'b0};
        octl2 = {busy2, done2, reg_we2, err2};
        total++;
        if (octl2 !== ectl2) $display("FAIL %s ctl2 c=%0d got %b exp %b", nm, c, octl2, ectl2);
        else passed++;
        if (c == lat) begin
          total++;
          if ({reg_wdata2, tcyc2_m2} !== {data, 2'(sat(3 + wr, 2))})
            $display("FAIL %s sat2 got %h/%0d exp %h/%0d", nm, reg_wdata2, tcyc2_m2, data, sat(3 + wr, 2));
          else passed++;
        end
      end else begin
        ectl2 = {3'b000, c == 1 || (poke && c == 3)};
        octl2 = {busy2, bus_mreq2, reg_we2, err2};
        total++;
        if (octl2 !== ectl2) $display("FAIL %s noidx2 c=%0d got %b exp %b", nm, c, octl2, ectl2);
        else passed++;
      end
    end
    start = 1'b0;
    bus_wait = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, bus_mreq, bus_rd, reg_we, done, err, bus_addr, ip_out, tcyc_m2, tcyc_m3, tcyc_m4, reg_sel, reg_wdata} !== '0)
      $display("FAIL reset outputs got busy=%b addr=%h ip=%h", busy, bus_addr, ip_out);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, bus_mreq, done, err, busy2, done2, err2} !== '0)
      $display("FAIL reset idle got busy=%b mreq=%b done=%b", busy, bus_mreq, done);
    else passed++;
  endtask

  task automatic test_hl;
    hl = 16'h1234; mem[16'h1234] = 8'h5A; ip_in = 16'h0101;
    do_load(0, 0, 0, 0, 1'b0, "hl");
  endtask

  task automatic test_indexed_wrap;
    ix = 16'h0002; ip_in = 16'hFFFF; mem[16'hFFFF] = 8'hFD;
    do_load(3, 7, 0, 0, 1'b0, "ix_wrap");
    iy = 16'hFF80; ip_in = 16'h4000; mem[16'h4000] = 8'h7F;
    do_load(4, 1, 0, 0, 1'b0, "iy_pos");
  endtask

  task automatic test_wait;
    do_load(2, 7, 0, 2, 1'b0, "wait_de");
    do_load(4, 5, 2, 1, 1'b0, "wait_idx");
    do_load(0, 3, 0, 5, 1'b0, "wait_sat");
  endtask

  task automatic test_illegal(input int m, input int rr, input string nm);
    mode = 3'(m);
    r = 3'(rr);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    total++;
    if ({err, busy, bus_mreq, reg_we, err2, busy2, bus_mreq2, reg_we2} !== 8'b1000_1000)
      $display("FAIL %s pulse got %b exp 10001000", nm, {err, busy, bus_mreq, reg_we, err2, busy2, bus_mreq2, reg_we2});
    else passed++;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({err, busy, bus_mreq, reg_we, err2, busy2, bus_mreq2, reg_we2} !== 8'b0)
      $display("FAIL %s after got %b exp 00000000", nm, {err, busy, bus_mreq, reg_we, err2, busy2, bus_mreq2, reg_we2});
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    mode = 3'd3; r = 3'd2; ix = 16'($urandom); ip_in = 16'($urandom);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (c == 5) reset = 1'b1;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b1) $display("FAIL rstmid busy_before got %b exp 1", busy);
    else passed++;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, bus_mreq, bus_rd, reg_we, done, err, bus_addr, ip_out, tcyc_m2, tcyc_m3, tcyc_m4, reg_sel, reg_wdata} !== '0)
      $display("FAIL rstmid outputs got busy=%b addr=%h ip=%h m2=%0d", busy, bus_addr, ip_out, tcyc_m2);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen |= done | reg_we | busy;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rstmid aborted got activity %b exp 0", seen);
    else passed++;
    hl = 16'h0F0F;
    do_load(0, 4, 0, 0, 1'b0, "rstmid_hl");
  endtask

  task automatic test_start_busy;
    do_load(1, 7, 0, 1, 1'b1, "busy_bc");
    do_load(0, 4, 0, 0, 1'b0, "after_fin");
  endtask

  task automatic test_back_to_back;
    int m, rr, t;
    for (int i = 0; i < 25; i++) begin
      m = $urandom_range(0, 4);
      t = $urandom_range(0, 6);
      rr = (m == 1 || m == 2 || t == 6) ? 7 : t;
      do_load(m, rr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset;
    test_hl;
    test_indexed_wrap;
    test_wait;
    test_illegal(0, 6, "ill_r6");
    test_illegal(1, 3, "ill_bc_r3");
    test_illegal(6, 0, "ill_mode6");
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
